// File: rtl/imm_pkg.sv
// Shared definitions for the immediate narrower and the sign-extender-side checks.
package imm_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IMM_W_DEF  = 4;

    // Clamp values for a 4-bit signed immediate field.
    localparam logic [3:0] IMM_MAX = 4'b0111;
    localparam logic [3:0] IMM_MIN = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/imm_narrower_sat_counter.sv
// Counter with enable and asynchronous active-low clear that sticks at its maximum value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/imm_narrower.sv
// Recovers a narrow signed immediate from a sign-extended word by scanning off
// redundant sign bits one per cycle, then holds the result for a valid/ready consumer.
module imm_narrower
    import imm_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_fits,
    output logic [4:0]        out_width,
    output logic [7:0]        overflow_count
);

    localparam logic [4:0] WCNT_INIT = 5'(DATA_W);
    localparam logic [4:0] IMM_LIMIT = 5'(IMM_W);

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  orig_q, orig_d;
    logic signed [DATA_W-1:0]  shreg_q, shreg_d;
    logic [4:0]                wcnt_q, wcnt_d;
    logic [IMM_W-1:0]          out_imm_q, out_imm_d;
    logic                      out_fits_q, out_fits_d;
    logic [4:0]                out_width_q, out_width_d;
    logic                      ovf_inc;

    // Non-fitting words either clamp to the field's extreme or keep their low bits.
    function automatic logic [IMM_W-1:0] narrow_imm(input logic signed [DATA_W-1:0] v,
                                                    input logic fits);
        if (fits || !SATURATE) begin
            return v[IMM_W-1:0];
        end else if (v[DATA_W-1]) begin
            return {1'b1, {(IMM_W-1){1'b0}}};
        end else begin
            return {1'b0, {(IMM_W-1){1'b1}}};
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        orig_d      = orig_q;
        shreg_d     = shreg_q;
        wcnt_d      = wcnt_q;
        out_imm_d   = out_imm_q;
        out_fits_d  = out_fits_q;
        out_width_d = out_width_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    orig_d  = $signed(in_data);
                    shreg_d = $signed(in_data);
                    wcnt_d  = WCNT_INIT;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Top two bits equal means the MSB is a redundant copy of the sign.
                if ((wcnt_q > 5'd1) && (shreg_q[DATA_W-1] == shreg_q[DATA_W-2])) begin
                    shreg_d = shreg_q <<< 1;
                    wcnt_d  = wcnt_q - 5'd1;
                end else begin
                    out_width_d = wcnt_q;
                    out_fits_d  = (wcnt_q <= IMM_LIMIT);
                    out_imm_d   = narrow_imm(orig_q, (wcnt_q <= IMM_LIMIT));
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            orig_q      <= '0;
            shreg_q     <= '0;
            wcnt_q      <= '0;
            out_imm_q   <= '0;
            out_fits_q  <= 1'b0;
            out_width_q <= '0;
        end else begin
            state_q     <= state_d;
            orig_q      <= orig_d;
            shreg_q     <= shreg_d;
            wcnt_q      <= wcnt_d;
            out_imm_q   <= out_imm_d;
            out_fits_q  <= out_fits_d;
            out_width_q <= out_width_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_imm   = out_imm_q;
    assign out_fits  = out_fits_q;
    assign out_width = out_width_q;

    assign ovf_inc = (state_q == HOLD) && out_ready && !out_fits_q;

    sat_counter #(
        .W(8)
    ) u_ovf_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ovf_inc),
        .count(overflow_count)
    );

endmodule

// File: tb/tb_imm_narrower.sv
// Randomized bench for imm_narrower against a range-based model of minimal signed width.
module tb_imm_narrower;
    import imm_pkg::*;

    localparam int DATA_W = 16;
    localparam int IMM_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IMM_W-1:0]  out_imm;
    logic              out_fits;
    logic [4:0]        out_width;
    logic [7:0]        overflow_count;

    int checks = 0;
    int errors = 0;
    int ovf_model = 0;

    imm_narrower #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .SATURATE(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_imm       (out_imm),
        .out_fits      (out_fits),
        .out_width     (out_width),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Smallest w such that the value lies in [-2^(w-1), 2^(w-1)-1].
    function automatic int ref_width(input logic [DATA_W-1:0] d);
        int v;
        v = int'($signed(d));
        for (int w = 1; w <= DATA_W; w++) begin
            if ((v >= -(1 <<< (w - 1))) && (v <= (1 <<< (w - 1)) - 1)) return w;
        end
        return DATA_W;
    endfunction

    function automatic logic [IMM_W-1:0] ref_imm(input logic [DATA_W-1:0] d, input int w);
        if (w <= IMM_W) return d[IMM_W-1:0];
        return (int'($signed(d)) < 0) ? IMM_MIN : IMM_MAX;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input int stall);
        int               w;
        int               edges;
        logic [IMM_W-1:0] ei;
        logic             ef;
        w  = ref_width(d);
        ei = ref_imm(d, w);
        ef = (w <= IMM_W);
        edges = 0;
        while (!in_ready && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        // The accepting edge is counted as edge 1.
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check_eq("latency", 32'(edges), 32'((DATA_W - w) + 2));
        check_eq("out_width", 32'(out_width), 32'(w));
        check_eq("out_imm", 32'(out_imm), 32'(ei));
        check_eq("out_fits", 32'(out_fits), 32'(ef));
        check_eq("in_ready_hold", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_imm", 32'(out_imm), 32'(ei));
            check_eq("stall_width", 32'(out_width), 32'(w));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (!ef && ovf_model < 255) ovf_model++;
        check_eq("post_valid", 32'(out_valid), 32'd0);
        check_eq("post_imm_kept", 32'(out_imm), 32'(ei));
        check_eq("ovf_count", 32'(overflow_count), 32'(ovf_model));
    endtask

    initial begin
        logic signed [DATA_W-1:0] s;
        int                       w;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(overflow_count), 32'd0);
        #21 rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_imm", 32'(out_imm), 32'd0);
        check_eq("rst_fits", 32'(out_fits), 32'd0);
        check_eq("rst_width", 32'(out_width), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        check_eq("idle_width", 32'(out_width), 32'd0);

        send(16'h0003, 0);
        send(16'hFFF9, 0);
        send(16'h0040, 0);
        send(16'h8000, 5);
        send(16'hFFFF, 0);
        send(16'h0000, 0);
        send(16'h7FFF, 1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_hold_width", 32'(out_width), 32'd16);
        check_eq("idle_no_valid", 32'(out_valid), 32'd0);

        for (int n = 0; n < 60; n++) begin
            w = $urandom_range(1, DATA_W);
            s = 16'($urandom) << (DATA_W - w);
            s = s >>> (DATA_W - w);
            send(s, $urandom_range(0, 2));
        end

        for (int n = 0; n < 260; n++) begin
            send(16'h8000, 0);
        end
        check_eq("ovf_saturated", 32'(overflow_count), 32'd255);

        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        ovf_model = 0;
        check_eq("midscan_valid", 32'(out_valid), 32'd0);
        check_eq("midscan_count", 32'(overflow_count), 32'd0);
        check_eq("midscan_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        send(16'hFFF9, 0);
        send(16'h0100, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
